// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button event generator.
// Defaults target a 50 MHz clock: ~2.6 ms sample tick, ~52 ms debounce, ~1 s long-press.
package btn_pkg;

  localparam int TICK_DIV_DEF       = 131072;
  localparam int DEBOUNCE_TICKS_DEF = 20;
  localparam int LONG_TICKS_DEF     = 384;

  // Pins are active-low, so the synchronizer powers up reading "released".
  localparam logic [1:0] SYNC_RST = 2'b11;

  typedef struct packed {
    logic press;
    logic rel;
    logic lng;
  } btn_evt_t;

endpackage

// File: rtl/btn_event_gen_if.sv
// Button pins in, debounced levels and single-cycle event pulses out.
// There is no valid/ready handshake: every output is registered and the consumer samples each cycle.
interface btn_event_gen_if #(
  parameter int N_BTN = 2
);

  logic [N_BTN-1:0] BTN;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;

  modport master (
    input  BTN,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );

  modport slave (
    output BTN,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, tick-based debounce counter and long-press hold counter.
// All outputs are registered; event pulses last exactly one clk_50m cycle.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int LONG_TICKS     = LONG_TICKS_DEF
) (
  input  logic     clk_50m,
  input  logic     rst_n,
  input  logic     tick,
  input  logic     btn_n,
  output logic     level,
  output btn_evt_t evt
);

  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_TICKS);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_TICKS - 1);

  logic [1:0]    sync_q;
  logic [DW-1:0] dcnt_q;
  logic [HW-1:0] hold_q;
  logic          level_q;
  btn_evt_t      evt_q;

  logic pressed_raw;
  logic differ;
  logic accept;

  always_comb begin
    pressed_raw = ~sync_q[1];
    differ      = (pressed_raw != level_q);
    accept      = tick && differ && (dcnt_q == D_LAST);
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= SYNC_RST;
      dcnt_q  <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      evt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_n};
      evt_q  <= '0;

      if (tick) begin
        if (!differ) begin
          dcnt_q <= '0;
        end else if (dcnt_q == D_LAST) begin
          dcnt_q    <= '0;
          level_q   <= ~level_q;
          evt_q.press <= ~level_q;
          evt_q.rel   <= level_q;
        end else begin
          dcnt_q <= dcnt_q + 1'b1;
        end
      end

      // An accepted release on the same tick clears hold, so release beats long-press.
      if (!level_q || accept) begin
        hold_q <= '0;
      end else if (tick && (hold_q < H_MAX)) begin
        hold_q    <= hold_q + 1'b1;
        evt_q.lng <= (hold_q == H_LAST);
      end
    end
  end

  assign level = level_q;
  assign evt   = evt_q;

endmodule

// File: rtl/btn_event_gen.sv
// Top: shared sample-tick generator plus one debounce channel per button.
// Turns raw active-low pins into debounced levels and press/release/long-press pulses.
module btn_event_gen
  import btn_pkg::*;
#(
  parameter int N_BTN          = 2,
  parameter int TICK_DIV       = TICK_DIV_DEF,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int LONG_TICKS     = LONG_TICKS_DEF
) (
  input logic              clk_50m,
  input logic              rst_n,
  btn_event_gen_if.master  bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = (tick_cnt_q == T_LAST);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_evt_t evt;
    logic     lvl;

    btn_debounce_ch #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .LONG_TICKS     (LONG_TICKS)
    ) u_ch (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .tick    (tick),
      .btn_n   (bus.BTN[i]),
      .level   (lvl),
      .evt     (evt)
    );

    assign bus.btn_level[i]   = lvl;
    assign bus.btn_press[i]   = evt.press;
    assign bus.btn_release[i] = evt.rel;
    assign bus.btn_long[i]    = evt.lng;
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen with TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=8.
// Expected events carry the cycle count since reset release at which they must appear.
module tb_btn_event_gen;

  localparam int W = 22;

  logic clk_50m = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;
  int   errors  = 0;
  int   checks  = 0;

  logic [W-1:0] exp_q[$];

  btn_event_gen_if #(.N_BTN(2)) bus ();

  btn_event_gen #(
    .N_BTN          (2),
    .TICK_DIV       (4),
    .DEBOUNCE_TICKS (3),
    .LONG_TICKS     (8)
  ) dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_50m = ~clk_50m;

  always @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // {cycle, press, release, long, level after the event}
  function automatic logic [W-1:0] ev(input int c, input logic [1:0] p, input logic [1:0] r,
                                      input logic [1:0] l, input logic [1:0] lv);
    logic [13:0] c14;
    c14 = c[13:0];
    return {c14, p, r, l, lv};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic at_cycle(input int n);
    while (cyc < n) @(negedge clk_50m);
  endtask

  task automatic set_btn(input logic [1:0] v);
    bus.BTN = v;
  endtask

  task automatic do_reset(input logic [1:0] btn);
    rst_n   = 1'b0;
    bus.BTN = btn;
    #1;
    chk("rst_level", {30'd0, bus.btn_level}, 32'd0);
    chk("rst_pulses", {26'd0, bus.btn_press, bus.btn_release, bus.btn_long}, 32'd0);
    repeat (3) @(negedge clk_50m);
    chk("rst_hold_out", {24'd0, bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic end_scn(input string name, input int n, input logic [1:0] lvl);
    at_cycle(n);
    chk({name, "_pending"}, exp_q.size(), 32'd0);
    chk({name, "_level"}, {30'd0, bus.btn_level}, {30'd0, lvl});
    exp_q.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic monitor_loop();
    logic [W-1:0] act;
    logic [W-1:0] e;
    forever begin
      @(negedge clk_50m);
      if (rst_n && (|bus.btn_press || |bus.btn_release || |bus.btn_long)) begin
        act = ev(cyc, bus.btn_press, bus.btn_release, bus.btn_long, bus.btn_level);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got %h expected none (cycle %0d)", act, cyc);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL event: got %h expected %h (cycle %0d)", act, e, cyc);
          end
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.BTN = 2'b11;
    fork
      monitor_loop();
    join_none

    // Both buttons held through reset: requalify, press on cycle 12.
    do_reset(2'b00);
    exp_q.push_back(ev(12, 2'b11, 2'b00, 2'b00, 2'b11));
    at_cycle(16);
    chk("reset_press_level", {30'd0, bus.btn_level}, 32'd3);
    at_cycle(20); set_btn(2'b11);
    exp_q.push_back(ev(32, 2'b00, 2'b11, 2'b00, 2'b00));
    end_scn("reset", 40, 2'b00);

    // Clean press on bit 0 at cycle 10 -> press at 24; release at 30 -> release at 44.
    do_reset(2'b11);
    at_cycle(10); set_btn(2'b10);
    exp_q.push_back(ev(24, 2'b01, 2'b00, 2'b00, 2'b01));
    at_cycle(23);
    chk("clean_pre_level", {30'd0, bus.btn_level}, 32'd0);
    at_cycle(30); set_btn(2'b11);
    exp_q.push_back(ev(44, 2'b00, 2'b01, 2'b00, 2'b00));
    end_scn("clean", 50, 2'b00);

    // Bounce every 5 cycles never gives 3 agreeing ticks; a 20-cycle press does.
    do_reset(2'b11);
    for (int k = 0; k < 8; k++) begin
      at_cycle(10 + 5 * k);
      set_btn({1'b1, (k % 2 == 1)});
    end
    at_cycle(58);
    chk("bounce_level", {30'd0, bus.btn_level}, 32'd0);
    at_cycle(60); set_btn(2'b10);
    exp_q.push_back(ev(72, 2'b01, 2'b00, 2'b00, 2'b01));
    at_cycle(80); set_btn(2'b11);
    exp_q.push_back(ev(92, 2'b00, 2'b01, 2'b00, 2'b00));
    end_scn("bounce", 100, 2'b00);

    // Long press: long 32 cycles after press, once only; then release.
    do_reset(2'b11);
    at_cycle(10); set_btn(2'b10);
    exp_q.push_back(ev(24, 2'b01, 2'b00, 2'b00, 2'b01));
    exp_q.push_back(ev(56, 2'b00, 2'b00, 2'b01, 2'b01));
    at_cycle(90);
    chk("long_hold_level", {30'd0, bus.btn_level}, 32'd1);
    at_cycle(100); set_btn(2'b11);
    exp_q.push_back(ev(112, 2'b00, 2'b01, 2'b00, 2'b00));
    end_scn("long", 120, 2'b00);

    // Release accepted on edge 56, the same tick hold would reach 8: release only.
    do_reset(2'b11);
    at_cycle(10); set_btn(2'b10);
    exp_q.push_back(ev(24, 2'b01, 2'b00, 2'b00, 2'b01));
    at_cycle(44); set_btn(2'b11);
    exp_q.push_back(ev(56, 2'b00, 2'b01, 2'b00, 2'b00));
    end_scn("simul", 80, 2'b00);

    // Reset with hold at 5 ticks: no release, then requalified press after reset.
    do_reset(2'b11);
    at_cycle(10); set_btn(2'b10);
    exp_q.push_back(ev(24, 2'b01, 2'b00, 2'b00, 2'b01));
    end_scn("midrst_pre", 46, 2'b01);
    do_reset(2'b10);
    exp_q.push_back(ev(12, 2'b01, 2'b00, 2'b00, 2'b01));
    at_cycle(20); set_btn(2'b11);
    exp_q.push_back(ev(32, 2'b00, 2'b01, 2'b00, 2'b00));
    end_scn("midrst_post", 40, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
